pe_data_loader: RTL and testbench

- Upstream feeder for one PU's array of PE wrappers.
- Accepts a word stream from the memory interface and scatters it round-robin across NUM_PE processing elements as {pe_id, valid, namespace_id} control plus data.
- After the load, pulses START to the PEs, waits for every PE's end-of-instruction flag, then reports done to the host-side controller.

---
 rtl/pe_ctrl_pkg.sv | 34 +++
 rtl/pe_data_loader_if.sv | 11 +
 rtl/pe_rr_counter.sv | 40 ++++
 rtl/pe_data_loader.sv | 126 ++++++++++++
 tb/tb_pe_data_loader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared CTRL_PE field layout, packing helper and loader FSM states
package pe_ctrl_pkg;

  localparam int PE_ID_WIDTH     = 2;
  localparam int NAMESPACE_WIDTH = 2;
  localparam int CTRL_PE_WIDTH   = PE_ID_WIDTH + 1 + NAMESPACE_WIDTH;

  // CTRL_PE is {pe_id, valid, namespace_id}, MSB first
  localparam int CTRL_NS_LSB     = 0;
  localparam int CTRL_VALID_BIT  = NAMESPACE_WIDTH;
  localparam int CTRL_PE_ID_LSB  = NAMESPACE_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_KICK     = 3'd2,
    ST_WAIT_EOI = 3'd3,
    ST_FIN      = 3'd4
  } loader_state_t;

  function automatic logic [CTRL_PE_WIDTH-1:0] pack_ctrl_pe(
    input logic [PE_ID_WIDTH-1:0]     pe_id,
    input logic                       valid,
    input logic [NAMESPACE_WIDTH-1:0] namespace_id
  );
    logic [CTRL_PE_WIDTH-1:0] word;
    word = '0;
    word[CTRL_PE_ID_LSB +: PE_ID_WIDTH]  = pe_id;
    word[CTRL_VALID_BIT]                 = valid;
    word[CTRL_NS_LSB +: NAMESPACE_WIDTH] = namespace_id;
    return word;
  endfunction

endpackage

// File: rtl/pe_data_loader_if.sv
// rtl/pe_data_loader_if.sv - word stream from the memory interface into the loader
interface pe_data_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pe_rr_counter.sv
// rtl/pe_rr_counter.sv - round-robin PE pointer plus per-PE word count with terminal flag
module pe_rr_counter #(
  parameter int NUM_PE      = 4,
  parameter int PTR_WIDTH   = 2,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [COUNT_WIDTH-1:0] limit,
  output logic [PTR_WIDTH-1:0]   ptr,
  output logic                   terminal
);

  logic [COUNT_WIDTH-1:0] word_cnt;
  logic                   ptr_wrap;

  // Wrap is explicit so NUM_PE below 2**PTR_WIDTH still cycles correctly
  assign ptr_wrap = (ptr == PTR_WIDTH'(NUM_PE - 1));
  assign terminal = ptr_wrap && (word_cnt == limit - COUNT_WIDTH'(1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ptr      <= '0;
      word_cnt <= '0;
    end else if (clear) begin
      ptr      <= '0;
      word_cnt <= '0;
    end else if (advance) begin
      if (ptr_wrap) begin
        ptr      <= '0;
        word_cnt <= word_cnt + COUNT_WIDTH'(1);
      end else begin
        ptr <= ptr + PTR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/pe_data_loader.sv
// rtl/pe_data_loader.sv - scatters a word stream round-robin over the PEs, kicks them, awaits EOI
module pe_data_loader
  import pe_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_PE          = 4,
  parameter int PE_ID_WIDTH     = pe_ctrl_pkg::PE_ID_WIDTH,
  parameter int NAMESPACE_WIDTH = pe_ctrl_pkg::NAMESPACE_WIDTH,
  parameter int CTRL_PE_WIDTH   = PE_ID_WIDTH + 1 + NAMESPACE_WIDTH,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic                       cfg_start,
  input  logic [NAMESPACE_WIDTH-1:0] cfg_namespace,
  input  logic [COUNT_WIDTH-1:0]     cfg_num_words,
  pe_data_loader_if.slave            s,
  output logic [DATA_WIDTH-1:0]      data_output,
  output logic [CTRL_PE_WIDTH-1:0]   CTRL_PE,
  output logic                       START,
  input  logic [NUM_PE-1:0]          pe_eoi,
  output logic                       busy,
  output logic                       done
);

  loader_state_t              state_q, state_d;
  logic [NAMESPACE_WIDTH-1:0] ns_q;
  logic [COUNT_WIDTH-1:0]     num_words_q;
  logic [PE_ID_WIDTH-1:0]     pe_ptr;
  logic                       last_beat;
  logic                       cfg_accept;
  logic                       beat;

  logic [DATA_WIDTH-1:0]      data_q;
  logic [PE_ID_WIDTH-1:0]     ctrl_pe_id_q;
  logic                       ctrl_valid_q;
  logic [NAMESPACE_WIDTH-1:0] ctrl_ns_q;

  assign s.tready    = (state_q == ST_LOAD);
  assign beat        = s.tvalid && s.tready;
  assign cfg_accept  = (state_q == ST_IDLE) && cfg_start;
  assign data_output = data_q;
  assign CTRL_PE     = pack_ctrl_pe(ctrl_pe_id_q, ctrl_valid_q, ctrl_ns_q);

  pe_rr_counter #(
    .NUM_PE      (NUM_PE),
    .PTR_WIDTH   (PE_ID_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_rr_counter (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .clear    (cfg_accept),
    .advance  (beat),
    .limit    (num_words_q),
    .ptr      (pe_ptr),
    .terminal (last_beat)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    START   = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (cfg_start) begin
          state_d = (cfg_num_words != '0) ? ST_LOAD : ST_KICK;
        end
      end
      ST_LOAD: begin
        if (beat && last_beat) begin
          state_d = ST_KICK;
        end
      end
      ST_KICK: begin
        START   = 1'b1;
        state_d = ST_WAIT_EOI;
      end
      ST_WAIT_EOI: begin
        if (&pe_eoi) begin
          state_d = ST_FIN;
        end
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Valid drops on idle cycles; pe_id, namespace and data keep the last beat's values
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      ns_q         <= '0;
      num_words_q  <= '0;
      data_q       <= '0;
      ctrl_pe_id_q <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_ns_q    <= '0;
    end else begin
      if (cfg_accept) begin
        ns_q        <= cfg_namespace;
        num_words_q <= cfg_num_words;
      end
      ctrl_valid_q <= beat;
      if (beat) begin
        data_q       <= s.tdata;
        ctrl_pe_id_q <= pe_ptr;
        ctrl_ns_q    <= ns_q;
      end
    end
  end

endmodule

// File: tb/tb_pe_data_loader.sv
// tb/tb_pe_data_loader.sv - directed scoreboard bench for pe_data_loader
module tb_pe_data_loader;

  localparam int NP = 4;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cfg_start;
  logic [1:0]  cfg_namespace;
  logic [15:0] cfg_num_words;
  logic [15:0] data_output;
  logic [4:0]  CTRL_PE;
  logic        START;
  logic [3:0]  pe_eoi;
  logic        busy;
  logic        done;

  always #5 ACLK = ~ACLK;

  pe_data_loader_if #(.DATA_WIDTH(16)) s_if ();

  pe_data_loader dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .cfg_namespace (cfg_namespace),
    .cfg_num_words (cfg_num_words),
    .s             (s_if),
    .data_output   (data_output),
    .CTRL_PE       (CTRL_PE),
    .START         (START),
    .pe_eoi        (pe_eoi),
    .busy          (busy),
    .done          (done)
  );

  typedef struct {
    logic [1:0]  pe_id;
    logic [1:0]  ns;
    logic [15:0] data;
  } beat_t;

  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          beats_seen = 0;
  logic        have_last = 1'b0;
  logic [15:0] last_data = '0;
  logic [1:0]  last_pe = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  // Output side of the scoreboard: every valid CTRL_PE cycle pops one expected beat
  always @(negedge ACLK) begin
    beat_t e;
    if (!ARESET) begin
      if (CTRL_PE[2]) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat_pe_id", 32'(CTRL_PE[4:3]), 32'(e.pe_id));
          check("beat_ns", 32'(CTRL_PE[1:0]), 32'(e.ns));
          check("beat_data", 32'(data_output), 32'(e.data));
          last_data = e.data;
          last_pe   = e.pe_id;
          have_last = 1'b1;
        end
      end else if (have_last) begin
        check("data_hold", 32'(data_output), 32'(last_data));
        check("pe_id_hold", 32'(CTRL_PE[4:3]), 32'(last_pe));
      end
    end
  end

  task automatic start_cfg(input logic [1:0] ns, input logic [15:0] nw);
    beats_seen    = 0;
    cfg_start     = 1'b1;
    cfg_namespace = ns;
    cfg_num_words = nw;
    tick();
    cfg_start     = 1'b0;
    cfg_namespace = 2'd0;
    cfg_num_words = 16'd0;
    check("busy_after_cfg", 32'(busy), 32'd1);
  endtask

  task automatic load_beats(input logic [1:0] ns, input int n, input int base,
                            input bit gaps, input bit inject);
    for (int i = 0; i < n; i++) begin
      check("tready_in_load", 32'(s_if.tready), 32'd1);
      s_if.tvalid = 1'b1;
      s_if.tdata  = 16'(base + i);
      exp_q.push_back('{pe_id: 2'(i % NP), ns: ns, data: 16'(base + i)});
      if (inject && i == 3) begin
        cfg_start     = 1'b1;
        cfg_namespace = ~ns;
        cfg_num_words = 16'd5;
      end
      tick();
      cfg_start = 1'b0;
      if (gaps && i != n - 1) begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = 16'hdead;
        check("tready_in_gap", 32'(s_if.tready), 32'd1);
        tick();
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tdata  = 16'h0;
  endtask

  task automatic kick_and_finish(input int wait_n, input logic [3:0] partial,
                                 input int exp_beats, input bit has_beats);
    check("start_pulse", 32'(START), 32'd1);
    check("tready_after_load", 32'(s_if.tready), 32'd0);
    check("ctrl_valid_at_start", 32'(CTRL_PE[2]), 32'(has_beats));
    pe_eoi = partial;
    for (int i = 0; i < wait_n; i++) begin
      tick();
      if (i == 0) check("beat_count", 32'(beats_seen), 32'(exp_beats));
      check("start_single", 32'(START), 32'd0);
      check("no_early_done", 32'(done), 32'd0);
      check("busy_in_wait", 32'(busy), 32'd1);
    end
    pe_eoi = 4'hF;
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("busy_in_fin", 32'(busy), 32'd1);
    pe_eoi = 4'h0;
    tick();
    check("done_single", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    cfg_start     = 1'b0;
    cfg_namespace = 2'd0;
    cfg_num_words = 16'd0;
    s_if.tvalid   = 1'b0;
    s_if.tdata    = 16'h0;
    pe_eoi        = 4'h0;

    repeat (3) tick();
    check("rst_tready", 32'(s_if.tready), 32'd0);
    check("rst_data", 32'(data_output), 32'd0);
    check("rst_ctrl", 32'(CTRL_PE), 32'd0);
    check("rst_start", 32'(START), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    ARESET = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);
    s_if.tvalid = 1'b1;
    tick();
    check("idle_ignores_tvalid", 32'(s_if.tready), 32'd0);
    s_if.tvalid = 1'b0;

    // Basic load: ns=2, two words per PE, tvalid held high
    start_cfg(2'd2, 16'd2);
    load_beats(2'd2, 8, 'h10, 1'b0, 1'b0);
    kick_and_finish(5, 4'h0, 8, 1'b1);

    // Gapped stream: tvalid toggles 1,0,1,0
    start_cfg(2'd2, 16'd2);
    load_beats(2'd2, 8, 'h20, 1'b1, 1'b0);
    kick_and_finish(3, 4'h0, 8, 1'b1);

    // Zero words: straight to KICK, no stream beats
    start_cfg(2'd3, 16'd0);
    check("zero_words_no_tready", 32'(s_if.tready), 32'd0);
    kick_and_finish(4, 4'h0, 0, 1'b0);

    // Partial EOI holds off done
    start_cfg(2'd1, 16'd1);
    load_beats(2'd1, 4, 'h30, 1'b0, 1'b0);
    kick_and_finish(20, 4'b0111, 4, 1'b1);

    // cfg_start during LOAD is ignored
    start_cfg(2'd2, 16'd2);
    load_beats(2'd2, 8, 'h50, 1'b0, 1'b1);
    kick_and_finish(3, 4'h0, 8, 1'b1);

    // Asynchronous reset after beat 3 of 8
    start_cfg(2'd2, 16'd2);
    load_beats(2'd2, 3, 'h60, 1'b0, 1'b0);
    #2;
    ARESET = 1'b1;
    #1;
    check("async_rst_data", 32'(data_output), 32'd0);
    check("async_rst_ctrl", 32'(CTRL_PE), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_tready", 32'(s_if.tready), 32'd0);
    check("async_rst_start", 32'(START), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    exp_q.delete();
    have_last = 1'b0;
    tick();
    tick();
    ARESET = 1'b0;
    tick();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_no_done", 32'(done), 32'd0);
    start_cfg(2'd1, 16'd1);
    load_beats(2'd1, 4, 'h70, 1'b0, 1'b0);
    kick_and_finish(2, 4'h0, 4, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
